// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the 5-stage MIPS pipeline control blocks.
//   REG_ADDR_W  : register index width
//   NUM_SLOTS   : shadow depth of the hazard controller (EX, MEM, WB)
//   SEL_*       : EX operand mux select encodings
//   hz_slot_t   : register-write metadata carried by one shadow slot
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_SLOTS  = 3;

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_WB      = 2'b01;
  localparam logic [1:0] SEL_MEM     = 2'b10;

  // rs/rt/use_* are only consulted while the slot sits in EX; later slots
  // simply carry them along.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  use_rs;
    logic                  use_rt;
  } hz_slot_t;

endpackage

// File: rtl/fwd_hazard_ctrl_hz_match.sv
// ---------------------------------------------------------------------------
// hz_match
// Combinational writer match: asserts writes_match when the given slot will
// write register src and the consumer actually reads it. Register 0 never
// matches.
//   slot         : shadow slot being examined as producer
//   src          : consumer source register index
//   use_src      : consumer reads src (already qualified by consumer valid)
//   writes_match : slot produces the value the consumer needs
// ---------------------------------------------------------------------------
module hz_match
  import mips_pipe_pkg::*;
(
  input  hz_slot_t              slot,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  use_src,
  output logic                  writes_match
);

  assign writes_match = use_src && slot.valid && slot.reg_write &&
                        (slot.dst == src) && (src != '0);

  logic unused_slot_bits;
  assign unused_slot_bits = ^{slot.mem_read, slot.rs, slot.rt,
                              slot.use_rs, slot.use_rt};

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and hazard controller for the 5-stage MIPS pipeline. Keeps a
// shadow copy of register-write metadata for the EX, MEM and WB slots and
// drives the EX operand mux selects plus the IF/ID stall.
//
// Build option FWD_HAZARD_FORWARD_EN:
//   defined   : forwarding mode; selects 10 (MEM) / 01 (WB) / 00 (regfile),
//               stall only on load-use.
//   undefined : stall-only mode; selects tied to 00, stall whenever a used
//               nonzero ID source is written by EX or MEM.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   id_valid..id_mem_read : decoded ID-stage instruction
//   flush                 : kill the ID instruction (bubble into EX)
//   freeze                : hold all slots
//   fwd_a_sel, fwd_b_sel  : EX operand A/B mux selects
//   stall                 : hold PC and IF/ID, bubble into EX
//   ex_valid              : EX shadow slot valid
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  // Must equal mips_pipe_pkg::REG_ADDR_W; the slot type is sized from it.
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  input  logic                  freeze,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  ex_valid
);

  import mips_pipe_pkg::hz_slot_t;
  import mips_pipe_pkg::SEL_REGFILE;
`ifdef FWD_HAZARD_FORWARD_EN
  import mips_pipe_pkg::SEL_WB;
  import mips_pipe_pkg::SEL_MEM;
`endif

  hz_slot_t id_slot;
  hz_slot_t ex_p0;
  hz_slot_t mem_p1;
  hz_slot_t wb_p2;

  logic ex_rs_mem, ex_rs_wb, ex_rt_mem, ex_rt_wb;
  logic id_rs_ex, id_rt_ex, id_rs_mem, id_rt_mem;
  logic hazard;

  always_comb begin
    id_slot           = '0;
    id_slot.valid     = id_valid;
    id_slot.dst       = id_dst;
    id_slot.reg_write = id_reg_write;
    id_slot.mem_read  = id_mem_read;
    id_slot.rs        = id_rs;
    id_slot.rt        = id_rt;
    id_slot.use_rs    = id_use_rs;
    id_slot.use_rt    = id_use_rt;
  end

  // ID -> EX -> MEM -> WB shadow. Freeze wins over stall and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_p0  <= '0;
      mem_p1 <= '0;
      wb_p2  <= '0;
    end else if (!freeze) begin
      wb_p2  <= mem_p1;
      mem_p1 <= ex_p0;
      if (stall || flush) begin
        ex_p0 <= '0;
      end else begin
        ex_p0 <= id_slot;
      end
    end
  end

  // EX consumer against MEM/WB producers
  hz_match u_ex_rs_mem (.slot(mem_p1), .src(ex_p0.rs), .use_src(ex_p0.valid && ex_p0.use_rs), .writes_match(ex_rs_mem));
  hz_match u_ex_rs_wb  (.slot(wb_p2),  .src(ex_p0.rs), .use_src(ex_p0.valid && ex_p0.use_rs), .writes_match(ex_rs_wb));
  hz_match u_ex_rt_mem (.slot(mem_p1), .src(ex_p0.rt), .use_src(ex_p0.valid && ex_p0.use_rt), .writes_match(ex_rt_mem));
  hz_match u_ex_rt_wb  (.slot(wb_p2),  .src(ex_p0.rt), .use_src(ex_p0.valid && ex_p0.use_rt), .writes_match(ex_rt_wb));

  // ID consumer against EX/MEM producers
  hz_match u_id_rs_ex  (.slot(ex_p0),  .src(id_rs), .use_src(id_use_rs), .writes_match(id_rs_ex));
  hz_match u_id_rt_ex  (.slot(ex_p0),  .src(id_rt), .use_src(id_use_rt), .writes_match(id_rt_ex));
  hz_match u_id_rs_mem (.slot(mem_p1), .src(id_rs), .use_src(id_use_rs), .writes_match(id_rs_mem));
  hz_match u_id_rt_mem (.slot(mem_p1), .src(id_rt), .use_src(id_use_rt), .writes_match(id_rt_mem));

`ifdef FWD_HAZARD_FORWARD_EN
  // MEM holds the most recent producer, so it beats WB.
  always_comb begin
    fwd_a_sel = SEL_REGFILE;
    if (ex_rs_mem) begin
      fwd_a_sel = SEL_MEM;
    end else if (ex_rs_wb) begin
      fwd_a_sel = SEL_WB;
    end
    fwd_b_sel = SEL_REGFILE;
    if (ex_rt_mem) begin
      fwd_b_sel = SEL_MEM;
    end else if (ex_rt_wb) begin
      fwd_b_sel = SEL_WB;
    end
  end

  // Only a load in EX is too late to forward; its data appears from WB.
  assign hazard = ex_p0.mem_read && (id_rs_ex || id_rt_ex);

  logic unused_mode_bits;
  assign unused_mode_bits = ^{id_rs_mem, id_rt_mem};
`else
  assign fwd_a_sel = SEL_REGFILE;
  assign fwd_b_sel = SEL_REGFILE;

  // No bypass paths: wait until the producer reaches WB, whose register
  // file write lands in the first half-cycle.
  assign hazard = id_rs_ex || id_rt_ex || id_rs_mem || id_rt_mem;

  logic unused_mode_bits;
  assign unused_mode_bits = ^{ex_rs_mem, ex_rs_wb, ex_rt_mem, ex_rt_wb};
`endif

  // A flushed instruction is discarded anyway, so it never stalls.
  assign stall    = id_valid && !flush && hazard;
  assign ex_valid = ex_p0.valid;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic       flush, freeze;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, ex_valid;

  int n_chk;
  int n_fail;

  fwd_hazard_ctrl #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .freeze(freeze), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .ex_valid(ex_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         clr;
    bit         val;
    logic [4:0] rs, rt;
    bit         urs, urt;
    logic [4:0] dst;
    bit         rw, mr, fl, fz;
    logic [1:0] ea, eb;
    bit         es, ev;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit clr, bit val, int rs, int rt, bit urs, bit urt,
                              int dst, bit rw, bit mr, bit fl, bit fz,
                              int ea, int eb, bit es, bit ev);
    vec_t v;
    v.clr = clr; v.val = val; v.rs = 5'(rs); v.rt = 5'(rt);
    v.urs = urs; v.urt = urt; v.dst = 5'(dst); v.rw = rw; v.mr = mr;
    v.fl = fl; v.fz = fz; v.ea = 2'(ea); v.eb = 2'(eb); v.es = es; v.ev = ev;
    return v;
  endfunction

  function automatic vec_t alu(bit clr, int rs, int rt, int dst, bit fl, bit fz,
                               int ea, int eb, bit es, bit ev);
    return mk(clr, 1, rs, rt, 1, 1, dst, 1, 0, fl, fz, ea, eb, es, ev);
  endfunction

  function automatic vec_t lw(bit clr, int dst, int ea, int eb, bit es, bit ev);
    return mk(clr, 1, 1, 0, 1, 0, dst, 1, 1, 0, 0, ea, eb, es, ev);
  endfunction

  function automatic vec_t nop(int ea, int eb, bit es, bit ev);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ea, eb, es, ev);
  endfunction

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    id_valid = r.val; id_rs = r.rs; id_rt = r.rt; id_use_rs = r.urs;
    id_use_rt = r.urt; id_dst = r.dst; id_reg_write = r.rw;
    id_mem_read = r.mr; flush = r.fl; freeze = r.fz;
  endtask

  task automatic idle();
    drive(nop(0, 0, 0, 0));
  endtask

  task automatic run_row(input int idx, input vec_t r);
    @(negedge clk);
    if (r.clr) begin
      idle();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
    end
    drive(r);
    #2;
    chk($sformatf("row%0d fwd_a_sel", idx), fwd_a_sel, r.ea);
    chk($sformatf("row%0d fwd_b_sel", idx), fwd_b_sel, r.eb);
    chk($sformatf("row%0d stall", idx), {1'b0, stall}, {1'b0, r.es});
    chk($sformatf("row%0d ex_valid", idx), {1'b0, ex_valid}, {1'b0, r.ev});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle();

`ifdef FWD_HAZARD_FORWARD_EN
    // add $3 <- $1,$2 ; sub $4 <- $3,$5
    tbl.push_back(alu(1, 1, 2, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(alu(0, 3, 5, 4, 0, 0, 0, 0, 0, 1));
    tbl.push_back(nop(2, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0));
    // add $3 ; nop ; or $6 <- $7,$3
    tbl.push_back(alu(1, 1, 2, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 1));
    tbl.push_back(alu(0, 7, 3, 6, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 1, 0, 1));
    // lw $8 ; add $9 <- $8,$8
    tbl.push_back(lw(1, 8, 0, 0, 0, 0));
    tbl.push_back(alu(0, 8, 8, 9, 0, 0, 0, 0, 1, 1));
    tbl.push_back(alu(0, 8, 8, 9, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(1, 1, 0, 1));
    // write $0 then read $0
    tbl.push_back(alu(1, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(alu(0, 0, 0, 9, 0, 0, 0, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 1));
    // MEM and WB both write $5, EX reads $5
    tbl.push_back(alu(1, 1, 2, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(alu(0, 1, 2, 5, 0, 0, 0, 0, 0, 1));
    tbl.push_back(alu(0, 5, 6, 7, 0, 0, 0, 0, 0, 1));
    tbl.push_back(nop(2, 0, 0, 1));
    // load-use with flush
    tbl.push_back(lw(1, 8, 0, 0, 0, 0));
    tbl.push_back(alu(0, 8, 8, 9, 1, 0, 0, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0));
    // load-use with 3 frozen cycles
    tbl.push_back(lw(1, 8, 0, 0, 0, 0));
    tbl.push_back(alu(0, 8, 8, 9, 0, 1, 0, 0, 1, 1));
    tbl.push_back(alu(0, 8, 8, 9, 0, 1, 0, 0, 1, 1));
    tbl.push_back(alu(0, 8, 8, 9, 0, 1, 0, 0, 1, 1));
    tbl.push_back(alu(0, 8, 8, 9, 0, 0, 0, 0, 1, 1));
    tbl.push_back(alu(0, 8, 8, 9, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(1, 1, 0, 1));
`else
    // add $3 <- $1,$2 ; sub $4 <- $3,$5 : two stall cycles
    tbl.push_back(alu(1, 1, 2, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(alu(0, 3, 5, 4, 0, 0, 0, 0, 1, 1));
    tbl.push_back(alu(0, 3, 5, 4, 0, 0, 0, 0, 1, 0));
    tbl.push_back(alu(0, 3, 5, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 1));
    // add $3 ; nop ; or $6 <- $7,$3 : one stall (producer in MEM)
    tbl.push_back(alu(1, 1, 2, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 1));
    tbl.push_back(alu(0, 7, 3, 6, 0, 0, 0, 0, 1, 0));
    tbl.push_back(alu(0, 7, 3, 6, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 1));
    // lw $8 ; add $9 <- $8,$8
    tbl.push_back(lw(1, 8, 0, 0, 0, 0));
    tbl.push_back(alu(0, 8, 8, 9, 0, 0, 0, 0, 1, 1));
    tbl.push_back(alu(0, 8, 8, 9, 0, 0, 0, 0, 1, 0));
    tbl.push_back(alu(0, 8, 8, 9, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 1));
    // write $0 then read $0
    tbl.push_back(alu(1, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(alu(0, 0, 0, 9, 0, 0, 0, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 1));
    // hazard with flush
    tbl.push_back(alu(1, 1, 2, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(alu(0, 3, 5, 4, 1, 0, 0, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0));
    // hazard with 3 frozen cycles
    tbl.push_back(alu(1, 1, 2, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(alu(0, 3, 5, 4, 0, 1, 0, 0, 1, 1));
    tbl.push_back(alu(0, 3, 5, 4, 0, 1, 0, 0, 1, 1));
    tbl.push_back(alu(0, 3, 5, 4, 0, 1, 0, 0, 1, 1));
    tbl.push_back(alu(0, 3, 5, 4, 0, 0, 0, 0, 1, 1));
    tbl.push_back(alu(0, 3, 5, 4, 0, 0, 0, 0, 1, 0));
    tbl.push_back(alu(0, 3, 5, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 1));
`endif
    // Sources named but not used, then an invalid ID with a matching source
    tbl.push_back(alu(1, 1, 2, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 3, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 3, 3, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 1));

    // Reset state
    #2;
    chk("reset fwd_a_sel", fwd_a_sel, 2'b00);
    chk("reset fwd_b_sel", fwd_b_sel, 2'b00);
    chk("reset stall", {1'b0, stall}, 2'b00);
    chk("reset ex_valid", {1'b0, ex_valid}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_row(i, tbl[i]);

    // Asynchronous reset in the middle of a load-use stall
    run_row(1000, lw(1, 3, 0, 0, 0, 0));
    run_row(1001, alu(0, 3, 5, 4, 0, 0, 0, 0, 1, 1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset stall", {1'b0, stall}, 2'b00);
    chk("midreset ex_valid", {1'b0, ex_valid}, 2'b00);
    chk("midreset fwd_a_sel", fwd_a_sel, 2'b00);
    @(negedge clk);
    #2;
    chk("held reset ex_valid", {1'b0, ex_valid}, 2'b00);
    rst_n = 1'b1;
    idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
